// File: rtl/mvmult_dot_pipe.sv
// mvmult_dot_pipe
//   Sequential signed fixed-point dot product with an ap_ctrl_hs style
//   handshake. One multiply-accumulate per cycle over N terms, then the
//   accumulator is scaled back to Q(W-F).F and either saturated or wrapped.
//
// Handshake: a request is accepted on a rising edge where ap_start=1 and the
//   block is idle. ap_ready pulses for the one cycle after that edge, when the
//   operands are held internally. ap_done stays high while the result is
//   valid and drops on the edge after ap_continue=1 is sampled while done.
//   ap_start is ignored unless idle, and ap_continue is ignored unless done.
//
// Ports
//   ap_clk, ap_rst_n     clock, asynchronous active-low reset
//   ap_start             request one dot product
//   ap_continue          downstream has taken the result
//   vec_in, coef_in      N packed W-bit operands, element j at [j*W +: W]
//   bias_in, bias_en     optional accumulator start value (Q(W-F).F)
//   ap_idle/ready/done   handshake status
//   result, ovf          scaled result and its saturate/wrap flag
//   dbg_state            current FSM state, for observation only
module mvmult_dot_pipe #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int F   = 16,
  parameter int SAT = 1
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ap_start,
  input  logic           ap_continue,
  input  logic [N*W-1:0] vec_in,
  input  logic [N*W-1:0] coef_in,
  input  logic [W-1:0]   bias_in,
  input  logic           bias_en,
  output logic           ap_idle,
  output logic           ap_ready,
  output logic           ap_done,
  output logic [W-1:0]   result,
  output logic           ovf,
  output logic [1:0]     dbg_state
);

  localparam int JW = $clog2(N);
  // 2W-bit products, N of them plus a bias of at most W+F bits: the extra
  // clog2(N)+1 bits keep the running sum exact.
  localparam int AW = 2*W + $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [JW-1:0]        j;
  logic signed [AW-1:0] acc;
  logic [N*W-1:0]       vec_r;
  logic [N*W-1:0]       coef_r;
  logic                 ready_r;

  logic                 start_acc;
  logic                 last_term;
  logic signed [W-1:0]  op_c;
  logic signed [W-1:0]  op_v;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] acc_init;
  logic signed [AW-1:0] scaled;
  logic [AW-W:0]        scaled_top;
  logic                 out_ovf;
  logic [W-1:0]         sat_val;
  logic [W-1:0]         res_nxt;

  assign start_acc = (state == S_IDLE) && ap_start;
  assign last_term = (j == JW'(N - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start)    state_nxt = S_RUN;
      S_RUN:   if (last_term)   state_nxt = S_DONE;
      S_DONE:  if (ap_continue) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  assign op_c     = coef_r[j*W +: W];
  assign op_v     = vec_r[j*W +: W];
  assign prod     = op_c * op_v;
  assign prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  // Bias is aligned to the product scale (2F fractional bits).
  assign bias_ext = {{(AW-W){bias_in[W-1]}}, bias_in};
  assign acc_init = bias_en ? (bias_ext <<< F) : '0;

  // The final result is formed from acc_sum so the last term is included
  // on the same edge that enters DONE.
  assign scaled     = acc_sum >>> F;
  // In range exactly when every bit from the W-bit sign upward agrees.
  assign scaled_top = scaled[AW-1:W-1];
  assign out_ovf    = !((&scaled_top) || !(|scaled_top));
  assign sat_val    = scaled[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign res_nxt    = ((SAT != 0) && out_ovf) ? sat_val : scaled[W-1:0];

  // The accumulator is the holding register for bias_in/bias_en: they are
  // folded into it at acceptance, so later input changes have no effect.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      j       <= '0;
      acc     <= '0;
      vec_r   <= '0;
      coef_r  <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= start_acc;
      if (start_acc) begin
        vec_r  <= vec_in;
        coef_r <= coef_in;
        acc    <= acc_init;
        j      <= '0;
      end else if (state == S_RUN) begin
        acc <= acc_sum;
        if (last_term) begin
          result <= res_nxt;
          ovf    <= out_ovf;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign ap_ready  = ready_r;
  assign dbg_state = state;

endmodule
